picosoc_bus_arbiter: RTL and testbench
======================================

# picosoc_bus_arbiter

Two-master arbiter for the PicoSoC native memory bus (valid/ready/addr/wdata/wstrb/rdata, picorv32 handshake). It shares one downstream slave port (RAM, spimemio, UART, iomem decode) between the CPU (master 0) and a DMA or debug requester (master 1). Arbitration is round-robin, one transaction per grant. A per-transaction watchdog completes stalled accesses with a fixed error word, so a dead slave cannot hang the SoC.

## Interface
- TIMEOUT_CYCLES, 255: maximum BUSY cycles before the transaction is forced to complete; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'h dead_beef: read data returned on a timed-out access.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- m0_valid / m1_valid  in  1  master request; held high until that master's ready.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte write strobes; 0 means read.
- m0_ready / m1_ready  out  1  one-cycle completion strobe.
- m0_rdata / m1_rdata  out  32  read data, valid while the matching ready is high.
- s_valid  out  1  downstream request.
- s_addr, s_wdata, s_wstrb  out  32/32/4  muxed from the granted master; all zero when no master is granted.
- s_ready  in  1  downstream completion.
- s_rdata  in  32  downstream read data.
- grant  out  1  current or last owner (0 = m0, 1 = m1).
- busy  out  1  a transaction is in flight (BUSY or ERR).
- timeout_pulse  out  1  one-cycle strobe per timed-out transaction.
- timeout_count  out  8  saturating count of timeouts since reset.

## Operation
- States are IDLE, BUSY and ERR. Registers: state, owner, last_grant, cnt (width $clog2(TIMEOUT_CYCLES+1), minimum 1), timeout_count.
- **IDLE**
  - s_valid is 0 and both m*_ready are 0.
  - If exactly one m*_valid is high, owner is set to that master.
  - If both are high, owner is set to !last_grant.
  - Any grant moves to BUSY with cnt=0 and last_grant=owner.
- **BUSY**
  - s_valid = owner's m_valid. s_addr, s_wdata and s_wstrb come from the owner.
  - If s_ready is high: the owner's m_ready = 1 and m_rdata = s_rdata, both combinational. Next state is IDLE.
  - Else, if TIMEOUT_CYCLES != 0 and cnt == TIMEOUT_CYCLES-1: next state is ERR.
  - Otherwise cnt increments.
  - s_ready in the final watchdog cycle wins: the access completes normally and no timeout is recorded.
- **ERR** (one cycle)
  - s_valid = 0.
  - The owner's m_ready = 1 and m_rdata = TIMEOUT_RDATA.
  - timeout_pulse = 1 and timeout_count increments, saturating at 255.
  - Next state is IDLE.
  - Writes are silently dropped.
- **Owner drops m_valid in BUSY** (protocol violation): s_valid falls with it, no ready is returned, and the next state is IDLE.
- **Ready gating**: the non-owner's m_ready is always 0. Both m*_rdata are 0 unless their ready is high.
- **s_ready outside BUSY** is ignored.
- **Reset values**: state=IDLE, owner=0, last_grant=1 (m0 wins the first tie), cnt=0, timeout_count=0, grant=0. All outputs are 0.
- **Reset mid-transaction**: everything returns to reset values asynchronously and the in-flight access is abandoned with no ready. Masters must deassert valid under reset.

## Timing
- There is one arbitration bubble per transaction. m_valid rises in cycle N (IDLE), s_valid is high in cycle N+1, and with a zero-wait slave m_ready is high in N+1.
- A slave with W wait states gives m_ready at N+1+W.
- Timeout path: s_valid is high for exactly TIMEOUT_CYCLES cycles (N+1 .. N+TIMEOUT_CYCLES). m_ready and timeout_pulse occur at N+TIMEOUT_CYCLES+1.
- Back-to-back requests: the earliest next grant is the cycle after ready, giving a minimum 2-cycle transaction period.
- Under saturation from both masters, grants strictly alternate m0, m1, m0, ...
- s_* paths are purely combinational from registered owner/state and the master inputs. m_ready and m_rdata are combinational from s_ready and s_rdata, with no added latency.

## Test plan
- **Single m0 read, zero-wait slave** returning 32'h1234_5678: m0_valid at cycle 0 -> s_valid and m0_ready at cycle 1, m0_rdata=32'h1234_5678. m1_ready stays 0 and busy deasserts at cycle 2.
- **Simultaneous m0/m1 writes after reset, held for 6 transactions**: slave sees owners in order 0,1,0,1,0,1 with the correct s_wstrb and s_wdata each time. Each master gets exactly 3 readies.
- **Stuck slave, TIMEOUT_CYCLES=4, m1 read**: s_valid is high for exactly 4 cycles. Then m1_ready=1 with rdata=32'h dead_beef, timeout_pulse=1 for one cycle, timeout_count=1.
- **Boundary race, TIMEOUT_CYCLES=4**: s_ready on the 4th BUSY cycle returns the slave's data. timeout_pulse stays 0 and timeout_count is unchanged.
- **Saturation**: force 300 timeouts and check timeout_count stops at 255. With TIMEOUT_CYCLES=0, a slave stalled 1000 cycles must not time out.
- **Reset mid-operation**: assert reset in cycle 2 of a 10-wait-state access. All outputs go to 0 immediately with no ready. After release, m1 and m0 request together and m0 is granted first.

Source files
------------

// File: rtl/picosoc_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoSoC native memory bus, with a
// per-transaction watchdog that completes stalled accesses with a fixed word.
module picosoc_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hdead_beef
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        grant,
    output logic        busy,
    output logic        timeout_pulse,
    output logic [7:0]  timeout_count
);

    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic             owner, owner_d;
    logic             last_grant, last_grant_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       tcount_d;

    logic             owner_valid;
    logic             done;
    logic [31:0]      done_rdata;

    // State register; last_grant resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            cnt           <= '0;
            timeout_count <= 8'd0;
        end else begin
            state         <= state_d;
            owner         <= owner_d;
            last_grant    <= last_grant_d;
            cnt           <= cnt_d;
            timeout_count <= tcount_d;
        end
    end

    // Arbitration, watchdog and bus muxing.
    always_comb begin
        state_d       = state;
        owner_d       = owner;
        last_grant_d  = last_grant;
        cnt_d         = cnt;
        tcount_d      = timeout_count;
        s_valid       = 1'b0;
        s_addr        = 32'd0;
        s_wdata       = 32'd0;
        s_wstrb       = 4'd0;
        timeout_pulse = 1'b0;
        done          = 1'b0;
        done_rdata    = 32'd0;
        m0_ready      = 1'b0;
        m1_ready      = 1'b0;
        m0_rdata      = 32'd0;
        m1_rdata      = 32'd0;
        owner_valid   = owner ? m1_valid : m0_valid;

        case (state)
            S_IDLE: begin
                if (m0_valid || m1_valid) begin
                    owner_d      = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
                    last_grant_d = owner_d;
                    cnt_d        = '0;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                s_valid = owner_valid;
                s_addr  = owner ? m1_addr  : m0_addr;
                s_wdata = owner ? m1_wdata : m0_wdata;
                s_wstrb = owner ? m1_wstrb : m0_wstrb;
                if (!owner_valid) begin
                    state_d = S_IDLE;
                end else if (s_ready) begin
                    done       = 1'b1;
                    done_rdata = s_rdata;
                    state_d    = S_IDLE;
                end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_ERR: begin
                done          = 1'b1;
                done_rdata    = TIMEOUT_RDATA;
                timeout_pulse = 1'b1;
                if (timeout_count != 8'hff) begin
                    tcount_d = timeout_count + 8'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion is routed only to the owner; the other side stays at zero.
        m0_ready = done & ~owner;
        m1_ready = done &  owner;
        m0_rdata = m0_ready ? done_rdata : 32'd0;
        m1_rdata = m1_ready ? done_rdata : 32'd0;
    end

    assign grant = owner;
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Bench for picosoc_bus_arbiter: two instances (watchdog 4 and disabled) share
// stimulus; a transaction-level model checks every output on every cycle.
`timescale 1ns/1ps
module tb_picosoc_bus_arbiter;

    localparam logic [31:0] TO_RDATA = 32'hdead_beef;
    localparam int ST_IDLE = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_ERR  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;

    logic        d_m0_ready [2];
    logic        d_m1_ready [2];
    logic [31:0] d_m0_rdata [2];
    logic [31:0] d_m1_rdata [2];
    logic        d_s_valid  [2];
    logic [31:0] d_s_addr   [2];
    logic [31:0] d_s_wdata  [2];
    logic [3:0]  d_s_wstrb  [2];
    logic        d_grant    [2];
    logic        d_busy     [2];
    logic        d_pulse    [2];
    logic [7:0]  d_tcount   [2];

    int n_chk = 0;
    int n_pass = 0;

    // Transaction-level model state, one entry per instance.
    int m_st [2];
    bit m_own [2];
    bit m_prev [2];
    int m_stall [2];
    int m_tc [2];
    bit rdy0_i0, rdy1_i0;

    picosoc_bus_arbiter #(.TIMEOUT_CYCLES(4)) u0 (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(d_m0_ready[0]), .m0_rdata(d_m0_rdata[0]),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(d_m1_ready[0]), .m1_rdata(d_m1_rdata[0]),
        .s_valid(d_s_valid[0]), .s_addr(d_s_addr[0]), .s_wdata(d_s_wdata[0]),
        .s_wstrb(d_s_wstrb[0]), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(d_grant[0]), .busy(d_busy[0]), .timeout_pulse(d_pulse[0]),
        .timeout_count(d_tcount[0])
    );

    picosoc_bus_arbiter #(.TIMEOUT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(d_m0_ready[1]), .m0_rdata(d_m0_rdata[1]),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(d_m1_ready[1]), .m1_rdata(d_m1_rdata[1]),
        .s_valid(d_s_valid[1]), .s_addr(d_s_addr[1]), .s_wdata(d_s_wdata[1]),
        .s_wstrb(d_s_wstrb[1]), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(d_grant[1]), .busy(d_busy[1]), .timeout_pulse(d_pulse[1]),
        .timeout_count(d_tcount[1])
    );

    always #5 clk = ~clk;

    function automatic int watchdog_of(int k);
        return (k == 0) ? 4 : 0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset(int k);
        m_st[k] = ST_IDLE; m_own[k] = 1'b0; m_prev[k] = 1'b1;
        m_stall[k] = 0; m_tc[k] = 0;
    endtask

    // Per-cycle comparison against the model, then advance the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin : per_inst
            bit          ov;
            logic        ev, er0, er1, ep;
            logic [31:0] ea, ew, ed0, ed1;
            logic [3:0]  es;
            if (reset) model_reset(k);
            ov = m_own[k] ? m1_valid : m0_valid;
            ev = 0; ea = 0; ew = 0; es = 0; er0 = 0; er1 = 0; ed0 = 0; ed1 = 0; ep = 0;
            if (m_st[k] == ST_BUSY) begin
                ev = ov;
                ea = m_own[k] ? m1_addr : m0_addr;
                ew = m_own[k] ? m1_wdata : m0_wdata;
                es = m_own[k] ? m1_wstrb : m0_wstrb;
                if (ov && s_ready) begin
                    if (m_own[k]) begin er1 = 1; ed1 = s_rdata; end
                    else begin er0 = 1; ed0 = s_rdata; end
                end
            end else if (m_st[k] == ST_ERR) begin
                ep = 1;
                if (m_own[k]) begin er1 = 1; ed1 = TO_RDATA; end
                else begin er0 = 1; ed0 = TO_RDATA; end
            end
            chk($sformatf("u%0d.s_valid", k), d_s_valid[k], ev);
            chk($sformatf("u%0d.s_addr", k), d_s_addr[k], ea);
            chk($sformatf("u%0d.s_wdata", k), d_s_wdata[k], ew);
            chk($sformatf("u%0d.s_wstrb", k), d_s_wstrb[k], es);
            chk($sformatf("u%0d.m0_ready", k), d_m0_ready[k], er0);
            chk($sformatf("u%0d.m1_ready", k), d_m1_ready[k], er1);
            chk($sformatf("u%0d.m0_rdata", k), d_m0_rdata[k], ed0);
            chk($sformatf("u%0d.m1_rdata", k), d_m1_rdata[k], ed1);
            chk($sformatf("u%0d.grant", k), d_grant[k], m_own[k]);
            chk($sformatf("u%0d.busy", k), d_busy[k], m_st[k] != ST_IDLE);
            chk($sformatf("u%0d.timeout_pulse", k), d_pulse[k], ep);
            chk($sformatf("u%0d.timeout_count", k), 32'(d_tcount[k]), 32'(m_tc[k]));
            if (k == 0) begin rdy0_i0 = er0; rdy1_i0 = er1; end
            if (!reset) begin
                case (m_st[k])
                    ST_IDLE: if (m0_valid || m1_valid) begin
                        m_own[k]   = (m0_valid && m1_valid) ? !m_prev[k] : m1_valid;
                        m_prev[k]  = m_own[k];
                        m_stall[k] = 0;
                        m_st[k]    = ST_BUSY;
                    end
                    ST_BUSY: begin
                        if (!ov || s_ready) m_st[k] = ST_IDLE;
                        else begin
                            m_stall[k]++;
                            if (watchdog_of(k) != 0 && m_stall[k] == watchdog_of(k)) m_st[k] = ST_ERR;
                        end
                    end
                    default: begin
                        if (m_tc[k] < 255) m_tc[k]++;
                        m_st[k] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; m0_valid = 0; m1_valid = 0; s_ready = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic new_req(int m);
        logic [3:0] st;
        st = ($urandom % 2 == 0) ? 4'($urandom) : 4'd0;
        if (m == 0) begin
            m0_valid = 1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = st;
        end else begin
            m1_valid = 1; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = st;
        end
    endtask

    initial begin
        int r0, r1, sv, np, p1;
        bit seen;

        // Single m0 read, zero-wait slave.
        do_reset();
        s_ready = 1; s_rdata = 32'h1234_5678;
        m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 0;
        smp(); chk("t1 s_valid c0", d_s_valid[0], 0);
        tick(); smp();
        chk("t1 s_valid c1", d_s_valid[0], 1);
        chk("t1 m0_ready c1", d_m0_ready[0], 1);
        chk("t1 m0_rdata c1", d_m0_rdata[0], 32'h1234_5678);
        chk("t1 m1_ready c1", d_m1_ready[0], 0);
        tick(); m0_valid = 0; smp();
        chk("t1 busy c2", d_busy[0], 0);

        // Saturating writes from both masters: strict alternation from m0.
        do_reset();
        s_ready = 1;
        m0_addr = 32'h0000_1000; m0_wdata = 32'haaaa_0000; m0_wstrb = 4'hf;
        m1_addr = 32'h0000_2000; m1_wdata = 32'hbbbb_1111; m1_wstrb = 4'h3;
        m0_valid = 1; m1_valid = 1;
        r0 = 0; r1 = 0;
        for (int c = 0; c < 40 && (r0 + r1) < 6; c++) begin
            smp();
            if (d_s_valid[0]) begin
                chk("t2 owner order", d_grant[0], 32'((r0 + r1) % 2));
                chk("t2 s_wdata", d_s_wdata[0], ((r0 + r1) % 2 == 0) ? 32'haaaa_0000 : 32'hbbbb_1111);
                chk("t2 s_wstrb", d_s_wstrb[0], ((r0 + r1) % 2 == 0) ? 4'hf : 4'h3);
            end
            r0 += int'(d_m0_ready[0]);
            r1 += int'(d_m1_ready[0]);
            tick();
        end
        m0_valid = 0; m1_valid = 0;
        chk("t2 m0 readies", r0, 3);
        chk("t2 m1 readies", r1, 3);

        // Stuck slave, m1 read, watchdog of 4.
        do_reset();
        s_ready = 0; m1_valid = 1; m1_addr = 32'h0300_0000; m1_wstrb = 0;
        sv = 0; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            smp();
            sv += int'(d_s_valid[0]);
            if (d_m1_ready[0]) begin
                seen = 1;
                chk("t3 m1_rdata", d_m1_rdata[0], TO_RDATA);
                chk("t3 timeout_pulse", d_pulse[0], 1);
            end
            tick();
        end
        m1_valid = 0;
        chk("t3 ready seen", seen, 1);
        chk("t3 s_valid cycles", sv, 4);
        smp();
        chk("t3 pulse after", d_pulse[0], 0);
        chk("t3 timeout_count", d_tcount[0], 1);

        // Ready on the final watchdog cycle completes normally.
        tick();
        m0_valid = 1; m0_addr = 32'h0000_0200; m0_wstrb = 0; s_rdata = 32'hcafe_f00d;
        for (int c = 0; c < 4; c++) tick();
        s_ready = 1; smp();
        chk("t4 m0_ready", d_m0_ready[0], 1);
        chk("t4 m0_rdata", d_m0_rdata[0], 32'hcafe_f00d);
        chk("t4 timeout_pulse", d_pulse[0], 0);
        tick(); m0_valid = 0; s_ready = 0; smp();
        chk("t4 timeout_count", d_tcount[0], 1);
        chk("t4 busy", d_busy[0], 0);

        // 300 timeouts saturate the count; disabled watchdog never fires.
        tick();
        m0_valid = 1; s_ready = 0;
        np = 0; p1 = 0;
        for (int c = 0; c < 3000 && np < 300; c++) begin
            smp();
            np += int'(d_pulse[0]);
            p1 += int'(d_pulse[1]);
            tick();
        end
        m0_valid = 0;
        chk("t5 pulses", np, 300);
        chk("t5 timeout_count sat", d_tcount[0], 255);
        chk("t5 no-watchdog count", d_tcount[1], 0);
        chk("t5 no-watchdog pulses", p1, 0);

        // Reset in the middle of an m1 access.
        tick();
        m1_valid = 1; m1_addr = 32'h0000_0400; m1_wstrb = 0; s_ready = 0;
        tick(); tick();
        #2; reset = 1; m1_valid = 0; #1;
        for (int k = 0; k < 2; k++) begin
            chk("t6 busy", d_busy[k], 0);
            chk("t6 s_valid", d_s_valid[k], 0);
            chk("t6 s_addr", d_s_addr[k], 0);
            chk("t6 m1_ready", d_m1_ready[k], 0);
            chk("t6 grant", d_grant[k], 0);
            chk("t6 timeout_count", d_tcount[k], 0);
        end
        tick(); reset = 0;
        m0_valid = 1; m0_addr = 32'h0000_0500; m1_valid = 1; m1_addr = 32'h0000_0600;
        smp(); chk("t6 s_valid c0", d_s_valid[0], 0);
        tick(); smp();
        chk("t6 first grant", d_grant[0], 0);
        chk("t6 s_addr", d_s_addr[0], 32'h0000_0500);
        tick(); m0_valid = 0; m1_valid = 0;

        // Randomized traffic; masters follow the model's handshake for u0.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (m0_valid) begin
                if (rdy0_i0) begin
                    if ($urandom % 2 == 0) new_req(0); else m0_valid = 0;
                end
            end else if ($urandom % 3 == 0) new_req(0);
            if (m1_valid) begin
                if (rdy1_i0) begin
                    if ($urandom % 2 == 0) new_req(1); else m1_valid = 0;
                end
            end else if ($urandom % 3 == 0) new_req(1);
            s_ready = ($urandom % 3 == 0);
            s_rdata = $urandom;
            tick();
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
